encoder: RTL and testbench

- Registered 4-to-2 priority encoder with valid and multi-hot flags.
- Converts four request lines into a 2-bit index of the active line.
- Used in the combinational-blocks area wherever a one-hot or few-hot select must become a binary code.
- Outputs are registered on clk, with one-cycle latency.

---
 rtl/encoder.sv | 76 +++++++
 tb/tb_encoder.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/encoder.sv
// Registered 4-to-2 priority encoder with valid and multi-hot flags.
// Four request lines are reduced to the 2-bit index of the winning line;
// the winner is the highest or lowest active index depending on
// PRIORITY_HIGH. All outputs come straight from flops, one cycle after
// the inputs are sampled.
module encoder #(
  parameter bit PRIORITY_HIGH = 1'b1,  // 1: highest active index wins, 0: lowest
  parameter bit HOLD_ON_IDLE  = 1'b0   // 1: code keeps last value when idle, 0: code -> 00
) (
  input  logic clk,
  input  logic rst,
  input  logic d3,
  input  logic d2,
  input  logic d1,
  input  logic d0,
  output logic y1,
  output logic y0,
  output logic valid,
  output logic multi
);

  logic [3:0] req;
  logic [1:0] code_d;
  logic [1:0] code_q;
  logic       valid_d;
  logic       multi_d;
  logic       valid_q;
  logic       multi_q;

  assign req = {d3, d2, d1, d0};

  // Next-state: pick the winning index and derive the flags from the raw requests.
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    code_d  = 2'b00;
    valid_d = |req;
    // Clearing the lowest set bit leaves something only if two or more bits were set.
    multi_d = |(req & (req - 4'd1));

    if (req == 4'b0000) begin
      code_d = HOLD_ON_IDLE ? code_q : 2'b00;
    end else if (PRIORITY_HIGH) begin
      if      (req[3]) code_d = 2'd3;
      else if (req[2]) code_d = 2'd2;
      else if (req[1]) code_d = 2'd1;
      else             code_d = 2'd0;
    end else begin
      if      (req[0]) code_d = 2'd0;
      else if (req[1]) code_d = 2'd1;
      else if (req[2]) code_d = 2'd2;
      else             code_d = 2'd3;
    end
  end

  // Output registers; reset clears everything at once, including a held code.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      code_q  <= 2'b00;
      valid_q <= 1'b0;
      multi_q <= 1'b0;
    end else begin
      code_q  <= code_d;
      valid_q <= valid_d;
      multi_q <= multi_d;
    end
  end

  assign y1    = code_q[1];
  assign y0    = code_q[0];
  assign valid = valid_q;
  assign multi = multi_q;

endmodule

// File: tb/tb_encoder.sv
// Directed bench for the registered priority encoder. Three instances share
// the same stimulus: default parameters, lowest-index priority, and
// hold-on-idle. Inputs change on the falling edge; outputs are sampled
// 1 ns after the rising edge.
`timescale 1ns/1ps
module tb_encoder;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic d3 = 1'b0, d2 = 1'b0, d1 = 1'b0, d0 = 1'b0;

  logic y1_def, y0_def, valid_def, multi_def;
  logic y1_low, y0_low, valid_low, multi_low;
  logic y1_hld, y0_hld, valid_hld, multi_hld;

  int checks = 0;
  int errors = 0;

  // {y1, y0, valid, multi} per instance
  wire [3:0] o_def = {y1_def, y0_def, valid_def, multi_def};
  wire [3:0] o_low = {y1_low, y0_low, valid_low, multi_low};
  wire [3:0] o_hld = {y1_hld, y0_hld, valid_hld, multi_hld};

  always #5 clk = ~clk;

  encoder #(.PRIORITY_HIGH(1'b1), .HOLD_ON_IDLE(1'b0)) u_def (
    .clk(clk), .rst(rst), .d3(d3), .d2(d2), .d1(d1), .d0(d0),
    .y1(y1_def), .y0(y0_def), .valid(valid_def), .multi(multi_def));

  encoder #(.PRIORITY_HIGH(1'b0), .HOLD_ON_IDLE(1'b0)) u_low (
    .clk(clk), .rst(rst), .d3(d3), .d2(d2), .d1(d1), .d0(d0),
    .y1(y1_low), .y0(y0_low), .valid(valid_low), .multi(multi_low));

  encoder #(.PRIORITY_HIGH(1'b1), .HOLD_ON_IDLE(1'b1)) u_hld (
    .clk(clk), .rst(rst), .d3(d3), .d2(d2), .d1(d1), .d0(d0),
    .y1(y1_hld), .y0(y0_hld), .valid(valid_hld), .multi(multi_hld));

  // Drive one input vector on the falling edge, then sample after the next rising edge.
  task automatic apply(input logic [3:0] vec);
    @(negedge clk);
    {d3, d2, d1, d0} = vec;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    {d3, d2, d1, d0} = 4'b1111;
    rst = 1'b1;
    #1;  // before the first rising edge at 5 ns
    checks++;
    if (o_def !== 4'b0000) begin
      errors++; $display("FAIL reset_async_def: got %b expected 0000", o_def);
    end
    checks++;
    if (o_hld !== 4'b0000) begin
      errors++; $display("FAIL reset_async_hld: got %b expected 0000", o_hld);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (o_def !== 4'b0000) begin
      errors++; $display("FAIL reset_hold_def: got %b expected 0000", o_def);
    end
    checks++;
    if (o_low !== 4'b0000) begin
      errors++; $display("FAIL reset_hold_low: got %b expected 0000", o_low);
    end
    @(negedge clk);
    {d3, d2, d1, d0} = 4'b0000;
    rst = 1'b0;
  endtask

  task automatic test_one_hot();
    logic [3:0] vecs [4] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
    logic [1:0] codes[4] = '{2'b11, 2'b10, 2'b01, 2'b00};
    for (int i = 0; i < 4; i++) begin
      apply(vecs[i]);
      checks++;
      if (o_def !== {codes[i], 2'b10}) begin
        errors++; $display("FAIL one_hot_def[%b]: got %b expected %b", vecs[i], o_def, {codes[i], 2'b10});
      end
      checks++;
      if (o_low !== {codes[i], 2'b10}) begin
        errors++; $display("FAIL one_hot_low[%b]: got %b expected %b", vecs[i], o_low, {codes[i], 2'b10});
      end
    end
  endtask

  task automatic test_priority();
    // d3..d0, expected {code,valid,multi} for highest-wins and lowest-wins
    logic [3:0] vecs [3] = '{4'b0111, 4'b1010, 4'b1100};
    logic [3:0] exp_h[3] = '{4'b1011, 4'b1111, 4'b1111};
    logic [3:0] exp_l[3] = '{4'b0011, 4'b0111, 4'b1011};
    for (int i = 0; i < 3; i++) begin
      apply(vecs[i]);
      checks++;
      if (o_def !== exp_h[i]) begin
        errors++; $display("FAIL prio_high[%b]: got %b expected %b", vecs[i], o_def, exp_h[i]);
      end
      checks++;
      if (o_low !== exp_l[i]) begin
        errors++; $display("FAIL prio_low[%b]: got %b expected %b", vecs[i], o_low, exp_l[i]);
      end
    end
  endtask

  task automatic test_idle();
    apply(4'b1000);
    apply(4'b0000);
    checks++;
    if (o_def !== 4'b0000) begin
      errors++; $display("FAIL idle_clear_def: got %b expected 0000", o_def);
    end
    checks++;
    if (o_hld !== 4'b1100) begin
      errors++; $display("FAIL idle_hold_hld: got %b expected 1100", o_hld);
    end
    apply(4'b0000);
    checks++;
    if (o_hld !== 4'b1100) begin
      errors++; $display("FAIL idle_hold2_hld: got %b expected 1100", o_hld);
    end
  endtask

  task automatic test_latency();
    apply(4'b1000);
    @(negedge clk);
    {d3, d2, d1, d0} = 4'b0010;
    #1;  // inputs changed, no edge yet: outputs must not move
    checks++;
    if (o_def !== 4'b1110) begin
      errors++; $display("FAIL no_comb_path: got %b expected 1110", o_def);
    end
    @(posedge clk);
    #1;
    checks++;
    if (o_def !== 4'b0110) begin
      errors++; $display("FAIL latency_one: got %b expected 0110", o_def);
    end
  endtask

  task automatic test_reset_mid();
    apply(4'b0100);
    #2;  // between edges
    rst = 1'b1;
    #1;
    checks++;
    if (o_def !== 4'b0000) begin
      errors++; $display("FAIL mid_reset_def: got %b expected 0000", o_def);
    end
    checks++;
    if (o_hld !== 4'b0000) begin
      errors++; $display("FAIL mid_reset_hld: got %b expected 0000", o_hld);
    end
    @(negedge clk);
    {d3, d2, d1, d0} = 4'b0010;
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (o_def !== 4'b0110) begin
      errors++; $display("FAIL mid_release_def: got %b expected 0110", o_def);
    end
    // A held code must not survive reset: pulse reset, then go idle.
    apply(4'b1000);
    #2;
    rst = 1'b1;
    #1;
    @(negedge clk);
    {d3, d2, d1, d0} = 4'b0000;
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (o_hld !== 4'b0000) begin
      errors++; $display("FAIL hold_after_reset: got %b expected 0000", o_hld);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] vecs [4] = '{4'b1001, 4'b0011, 4'b0110, 4'b1111};
    logic [3:0] exp_h[4] = '{4'b1111, 4'b0111, 4'b1011, 4'b1111};
    logic [3:0] exp_l[4] = '{4'b0011, 4'b0011, 4'b0111, 4'b0011};
    for (int i = 0; i < 4; i++) begin
      apply(vecs[i]);
      checks++;
      if (o_def !== exp_h[i]) begin
        errors++; $display("FAIL b2b_high[%b]: got %b expected %b", vecs[i], o_def, exp_h[i]);
      end
      checks++;
      if (o_low !== exp_l[i]) begin
        errors++; $display("FAIL b2b_low[%b]: got %b expected %b", vecs[i], o_low, exp_l[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_one_hot();
    test_priority();
    test_idle();
    test_latency();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
